conv2d_tile_engine: RTL and testbench

//  Parametrised 2-D convolution tile engine: the next generation of the fixed 6x6/3x3 convolver.

---
 rtl/conv2d_tile_engine.sv | 158 +++++++++++++++
 tb/tb_conv2d_tile_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_tile_engine.sv
// conv2d_tile_engine: strided KxK convolution over a captured tile using shared external DSP lanes
module conv2d_tile_engine #(
  parameter int DATA_W = 8,
  parameter int IN_DIM = 6,
  parameter int K = 3,
  parameter int STRIDE = 1,
  parameter int LANES = 5,
  parameter int DSP_LAT = 1,
  parameter int OUT_W = 16,
  localparam int OUT_DIM = (IN_DIM - K) / STRIDE + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode_signed,
  input  logic relu_en,
  input  logic [4:0] out_shift,
  input  logic [IN_DIM-1:0][IN_DIM-1:0][DATA_W-1:0] input_tile,
  input  logic [K-1:0][K-1:0][DATA_W-1:0] kernel,
  output logic [OUT_DIM-1:0][OUT_DIM-1:0][OUT_W-1:0] c,
  output logic [LANES-1:0][17:0] dsp_a,
  output logic [LANES-1:0][17:0] dsp_b,
  input  logic [LANES-1:0][36:0] dsp_out,
  output logic dsp_ce,
  output logic busy,
  output logic done,
  output logic sat
);
  localparam int G = (K * K + LANES - 1) / LANES;
  localparam int ACC_W = 2 * DATA_W + 2 + $clog2(K * K);
  localparam int CW = (ACC_W > OUT_W ? ACC_W : OUT_W) + 2;
  localparam int GW = G > 1 ? $clog2(G) : 1;
  localparam int LW = DSP_LAT > 1 ? $clog2(DSP_LAT) : 1;
  localparam int OW = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1;
  localparam int IW = IN_DIM > 1 ? $clog2(IN_DIM) : 1;
  localparam int KW = K > 1 ? $clog2(K) : 1;
  localparam logic signed [CW-1:0] SMAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] SMIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [CW-1:0] UMAX = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  if (K > IN_DIM || (IN_DIM - K) % STRIDE != 0 || LANES < 1 || DSP_LAT < 1 || DATA_W > 17 || OUT_W < 1) begin : g_bad_params
    $error("conv2d_tile_engine: illegal parameter combination");
  end
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state;
  logic [IN_DIM-1:0][IN_DIM-1:0][DATA_W-1:0] tile_q;
  logic [K-1:0][K-1:0][DATA_W-1:0] kern_q;
  logic msigned_q, relu_q;
  logic [4:0] shift_q;
  logic [GW-1:0] grp;
  logic [LW-1:0] wcnt;
  logic [OW-1:0] row, col;
  logic [DSP_LAT-1:0] vld;
  logic signed [ACC_W-1:0] acc, psum;
  logic signed [CW-1:0] sh, rl, hi, lo;
  logic [OUT_W-1:0] res;
  logic clip, unused_dsp;
  logic [IW-1:0] ri, ci;
  logic [KW-1:0] kr, kc;
  int t;
  function automatic logic [17:0] ext(input logic [DATA_W-1:0] v, input logic s);
    return {{(18-DATA_W){s & v[DATA_W-1]}}, v};
  endfunction
  assign dsp_ce = state == ISSUE || state == WAIT;
  assign unused_dsp = ^dsp_out;
  // term t of the current group maps to kernel position (t/K, t%K)
  always_comb begin
    dsp_a = '0;
    dsp_b = '0;
    t = 0;
    kr = '0;
    kc = '0;
    ri = '0;
    ci = '0;
    for (int l = 0; l < LANES; l++) begin
      t = int'(grp) * LANES + l;
      kr = KW'(t / K);
      kc = KW'(t % K);
      ri = IW'(int'(row) * STRIDE + t / K);
      ci = IW'(int'(col) * STRIDE + t % K);
      if (state == ISSUE && t < K * K) begin
        dsp_a[l] = ext(tile_q[ri][ci], msigned_q);
        dsp_b[l] = ext(kern_q[kr][kc], msigned_q);
      end
    end
  end
  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++) psum = psum + $signed(dsp_out[l][ACC_W-1:0]);
  end
  always_comb begin
    sh = $signed({{(CW-ACC_W){acc[ACC_W-1]}}, acc}) >>> shift_q;
    rl = relu_q && msigned_q && sh < 0 ? '0 : sh;
    hi = msigned_q ? SMAX : UMAX;
    lo = msigned_q ? SMIN : '0;
    clip = rl > hi || rl < lo;
    res = rl > hi ? hi[OUT_W-1:0] : rl < lo ? lo[OUT_W-1:0] : rl[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      sat <= 1'b0;
      tile_q <= '0;
      kern_q <= '0;
      msigned_q <= 1'b0;
      relu_q <= 1'b0;
      shift_q <= '0;
      grp <= '0;
      wcnt <= '0;
      row <= '0;
      col <= '0;
      vld <= '0;
      acc <= '0;
    end else begin
      vld <= (vld << 1) | DSP_LAT'(state == ISSUE);
      acc <= vld[DSP_LAT-1] ? acc + psum : state == WRITE || state == IDLE ? '0 : acc;
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          tile_q <= input_tile;
          kern_q <= kernel;
          msigned_q <= mode_signed;
          relu_q <= relu_en;
          shift_q <= out_shift;
          busy <= 1'b1;
          sat <= 1'b0;
          grp <= '0;
          row <= '0;
          col <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          grp <= grp == GW'(G - 1) ? '0 : grp + 1'b1;
          wcnt <= '0;
          if (grp == GW'(G - 1)) state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == LW'(DSP_LAT - 1)) state <= WRITE;
        end
        WRITE: begin
          c[row][col] <= res;
          sat <= sat | clip;
          col <= col == OW'(OUT_DIM - 1) ? '0 : col + 1'b1;
          if (col == OW'(OUT_DIM - 1)) row <= row + 1'b1;
          state <= row == OW'(OUT_DIM - 1) && col == OW'(OUT_DIM - 1) ? DONE : ISSUE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_tile_engine.sv
// tb_conv2d_tile_engine: scoreboard bench for three configurations of the convolution engine
module tb_conv2d_tile_engine;
  logic clk = 0, rst = 1, start = 0, startx = 0, msg = 0, relu = 0;
  logic [4:0] shift = 0;
  logic [5:0][5:0][7:0] tile0;
  logic [6:0][6:0][7:0] tile2;
  logic [2:0][2:0][7:0] kern;
  logic [3:0][3:0][15:0] c0, c1;
  logic [2:0][2:0][15:0] c2;
  logic [4:0][17:0] a0, b0, a2, b2;
  logic [8:0][17:0] a1, b1;
  logic [4:0][36:0] p0, p2;
  logic [8:0][36:0] p1;
  logic [2:0][8:0][36:0] pipe1;
  logic ce0, ce1, ce2, busy0, busy1, busy2, done0, done1, done2, sat0, sat1, sat2;
  int cyc = 0, errs = 0, checks = 0;
  typedef struct {int kind; logic [15:0] v; logic s; int at;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  conv2d_tile_engine u0 (.clk(clk), .rst(rst), .start(start), .mode_signed(msg), .relu_en(relu),
    .out_shift(shift), .input_tile(tile0), .kernel(kern), .c(c0), .dsp_a(a0), .dsp_b(b0),
    .dsp_out(p0), .dsp_ce(ce0), .busy(busy0), .done(done0), .sat(sat0));
  conv2d_tile_engine #(.LANES(9), .DSP_LAT(3)) u1 (.clk(clk), .rst(rst), .start(startx),
    .mode_signed(msg), .relu_en(relu), .out_shift(shift), .input_tile(tile0), .kernel(kern),
    .c(c1), .dsp_a(a1), .dsp_b(b1), .dsp_out(p1), .dsp_ce(ce1), .busy(busy1), .done(done1), .sat(sat1));
  conv2d_tile_engine #(.IN_DIM(7), .STRIDE(2)) u2 (.clk(clk), .rst(rst), .start(startx),
    .mode_signed(msg), .relu_en(relu), .out_shift(shift), .input_tile(tile2), .kernel(kern),
    .c(c2), .dsp_a(a2), .dsp_b(b2), .dsp_out(p2), .dsp_ce(ce2), .busy(busy2), .done(done2), .sat(sat2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DSP lanes: registered signed multiplies, stalled when dsp_ce is low
  always @(posedge clk) if (ce0) for (int l = 0; l < 5; l++) p0[l] <= 37'($signed(a0[l])) * 37'($signed(b0[l]));
  always @(posedge clk) if (ce2) for (int l = 0; l < 5; l++) p2[l] <= 37'($signed(a2[l])) * 37'($signed(b2[l]));
  always @(posedge clk) if (ce1) begin
    for (int l = 0; l < 9; l++) pipe1[0][l] <= 37'($signed(a1[l])) * 37'($signed(b1[l]));
    pipe1[2:1] <= pipe1[1:0];
  end
  assign p1 = pipe1[2];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  function automatic int expv(input exp_t e, input int i, input int j);
    return e.kind == 0 ? 3 * (i + j) + 9 : e.kind == 2 ? 6 * (i + j) + 9 : int'(e.v);
  endfunction

  always @(negedge clk) if (done0) begin
    chk("u0 run pending at done", q0.size() > 0, 1);
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("u0 done edge", cyc, e0.at);
      chk("u0 sat", sat0, e0.s);
      chk("u0 busy at done", busy0, 0);
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
        chk($sformatf("u0 c[%0d][%0d]", i, j), c0[i][j], expv(e0, i, j));
    end
  end
  always @(negedge clk) if (done1) begin
    chk("u1 run pending at done", q1.size() > 0, 1);
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("u1 done edge", cyc, e1.at);
      chk("u1 sat", sat1, e1.s);
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
        chk($sformatf("u1 c[%0d][%0d]", i, j), c1[i][j], expv(e1, i, j));
    end
  end
  always @(negedge clk) if (done2) begin
    chk("u2 run pending at done", q2.size() > 0, 1);
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      chk("u2 done edge", cyc, e2.at);
      chk("u2 sat", sat2, e2.s);
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
        chk($sformatf("u2 c[%0d][%0d]", i, j), c2[i][j], expv(e2, i, j));
    end
  end

  task automatic ramp();
    for (int x = 0; x < 6; x++) for (int y = 0; y < 6; y++) tile0[x][y] = 8'(x + y + 1);
    for (int x = 0; x < 7; x++) for (int y = 0; y < 7; y++) tile2[x][y] = 8'(x + y + 1);
    kern = '0;
    for (int i = 0; i < 3; i++) kern[i][i] = 8'd1;
  endtask

  task automatic fill(input logic [7:0] tv, input logic [7:0] kv);
    for (int x = 0; x < 6; x++) for (int y = 0; y < 6; y++) tile0[x][y] = tv;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) kern[i][j] = kv;
  endtask

  task automatic wait_empty(input int lim);
    for (int k = 0; k < lim && q0.size() + q1.size() + q2.size() != 0; k++) @(posedge clk);
    chk("runs outstanding after time limit", q0.size() + q1.size() + q2.size(), 0);
    q0.delete();
    q1.delete();
    q2.delete();
    @(posedge clk);
  endtask

  task automatic run(input int kind, input logic [15:0] v, input logic s);
    exp_t e;
    @(posedge clk);
    #1 start = 1;
    e.kind = kind;
    e.v = v;
    e.s = s;
    e.at = cyc + 66;
    q0.push_back(e);
    @(posedge clk);
    #1 start = 0;
    wait_empty(150);
  endtask

  initial begin
    exp_t e;
    ramp();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset sat", sat0, 0);
    chk("reset dsp_ce", ce0, 0);
    chk("reset c all zero", c0 == '0, 1);
    chk("reset dsp_a zero", a0 == '0, 1);
    // all three configurations on the ramp tile; inputs are scrambled right after the start edge
    @(posedge clk);
    #1 start = 1;
    startx = 1;
    e.kind = 0; e.v = 0; e.s = 0; e.at = cyc + 66; q0.push_back(e);
    e.at = cyc + 82; q1.push_back(e);
    e.kind = 2; e.at = cyc + 38; q2.push_back(e);
    @(posedge clk);
    #1 start = 0;
    startx = 0;
    msg = 1; relu = 1; shift = 3;
    fill(8'h55, 8'h33);
    tile2 = '1;
    chk("busy during run", busy0, 1);
    wait_empty(200);
    msg = 1; relu = 0; shift = 0;
    fill(8'h80, 8'h80);
    run(1, 16'h7FFF, 1);
    shift = 4;
    run(1, 16'd9216, 0);
    shift = 0;
    fill(8'h01, 8'hFF);
    relu = 1;
    run(1, 16'h0000, 0);
    relu = 0;
    run(1, 16'hFFF7, 0);
    msg = 0;
    fill(8'hFF, 8'hFF);
    run(1, 16'hFFFF, 1);
    // a second start mid-run must not disturb timing or results
    ramp();
    @(posedge clk);
    #1 start = 1;
    e.kind = 0; e.v = 0; e.s = 0; e.at = cyc + 66; q0.push_back(e);
    @(posedge clk);
    #1 start = 0;
    repeat (8) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("busy after ignored start", busy0, 1);
    wait_empty(150);
    // reset in the middle of a run: no done, outputs cleared
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (28) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid-run reset busy", busy0, 0);
    chk("mid-run reset done", done0, 0);
    chk("mid-run reset c all zero", c0 == '0, 1);
    chk("mid-run reset dsp_ce", ce0, 0);
    repeat (80) @(posedge clk);
    chk("still idle after reset", busy0, 0);
    run(0, 16'h0000, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
